// File: rtl/mul_pkg.sv
// mul_pkg: operation encoding, FSM states and iteration counts for the shift-add multiplier.
package mul_pkg;
    typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op;
    typedef enum logic [1:0] {S_IDLE, S_CAL, S_FINAL} mul_state_e;
    localparam int MUL_ITER_D = 64;
    localparam int MUL_ITER_W = 32;
    function automatic logic [63:0] abs64(input logic [63:0] x);
        return x[63] ? -x : x;
    endfunction
endpackage

// File: rtl/mul.sv
// mul: iterative radix-2 shift-add multiplier for RV64M (MUL/MULH/MULHSU/MULHU/MULW).
module mul
    import mul_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            mul_word,
    input  logic            en,
    input  mul_op           op,
    output logic [XLEN-1:0] out,
    output logic            out_valid,
    input  logic            out_ready
);
    mul_state_e        state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d, word_q, word_d, high_q, high_d;
    logic [XLEN-1:0]   cap_a, cap_b;
    logic              cap_neg, last;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] p;

    always_comb begin
        cap_a   = mul_word ? {32'b0, in1[31:0]} : (op == MULHU) ? in1 : abs64(in1);
        cap_b   = mul_word ? {32'b0, in2[31:0]} : (op == MULHU || op == MULHSU) ? in2 : abs64(in2);
        cap_neg = !mul_word && ((op == MULHSU) ? in1[63] : (op != MULHU) && (in1[63] ^ in2[63]));
        sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        last    = cnt_q == (word_q ? 6'(MUL_ITER_W - 1) : 6'(MUL_ITER_D - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        word_d  = word_q;
        high_d  = high_q;
        if (!en) begin
            state_d = S_IDLE;
            a_d     = '0;
            prod_d  = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            word_d  = 1'b0;
            high_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_d    = cap_a;
                    prod_d = {{XLEN{1'b0}}, cap_b};
                    cnt_d  = '0;
                    neg_d  = cap_neg;
                    word_d = mul_word;
                    high_d = !mul_word && (op != MUL);
                    if (ZERO_SKIP && (cap_a == '0 || cap_b == '0)) begin
                        prod_d  = '0;
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_CAL;
                    end
                end
                S_CAL: begin
                    prod_d  = {sum, prod_q[XLEN-1:1]};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = last ? S_FINAL : S_CAL;
                end
                S_FINAL: state_d = out_ready ? S_IDLE : S_FINAL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            word_q  <= 1'b0;
            high_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            word_q  <= word_d;
            high_q  <= high_d;
        end
    end

    // After 32 iterations the 64-bit word product sits in prod[95:32]; its low half is prod[63:32].
    always_comb begin
        p         = neg_q ? -prod_q : prod_q;
        out       = word_q ? {{32{prod_q[63]}}, prod_q[63:32]}
                  : high_q ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
        out_valid = state_q == S_FINAL;
    end
endmodule

// File: tb/tb_mul.sv
// tb_mul: randomized and directed checks of mul against a plain-arithmetic product model.
module tb_mul;
    import mul_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in1 = '0, in2 = '0;
    logic        mul_word = 1'b0, en = 1'b0, out_ready = 1'b0;
    mul_op       op = MUL;
    logic [63:0] out;
    logic        out_valid;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;
    bit          mdl_active = 1'b0;
    int          mdl_start = 0, mdl_lat = 0;
    logic [63:0] mdl_out = '0;

    mul dut (
        .clock(clock), .reset(reset), .in1(in1), .in2(in2), .mul_word(mul_word),
        .en(en), .op(op), .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] model(mul_op o, bit w, logic [63:0] x, logic [63:0] y);
        logic signed [127:0] sx, sy, pr;
        logic [63:0] pw;
        if (w) begin
            pw = {32'b0, x[31:0]} * {32'b0, y[31:0]};
            return {{32{pw[31]}}, pw[31:0]};
        end
        sx = (o == MULHU) ? {64'b0, x} : {{64{x[63]}}, x};
        sy = (o == MULHU || o == MULHSU) ? {64'b0, y} : {{64{y[63]}}, y};
        pr = sx * sy;
        return (o == MUL) ? pr[63:0] : pr[127:64];
    endfunction

    function automatic int lat_of(bit w, logic [63:0] x, logic [63:0] y);
        if (w ? (x[31:0] == 0 || y[31:0] == 0) : (x == 0 || y == 0)) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Compare process: DUT valid/out against the model on every cycle of an active operation.
    always @(negedge clock) begin
        if (mdl_active) begin
            n_chk++;
            if (out_valid !== ((cyc - mdl_start) >= mdl_lat)) begin
                n_fail++;
                $display("FAIL cmp_valid cyc=%0d edges=%0d got %b expected %b",
                         cyc, cyc - mdl_start, out_valid, (cyc - mdl_start) >= mdl_lat);
            end
            if (out_valid && (cyc - mdl_start) >= mdl_lat) begin
                n_chk++;
                if (out !== mdl_out) begin
                    n_fail++;
                    $display("FAIL cmp_out cyc=%0d got %h expected %h", cyc, out, mdl_out);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic start_op(mul_op o, bit w, logic [63:0] x, logic [63:0] y);
        op = o; mul_word = w; in1 = x; in2 = y; en = 1'b1; out_ready = 1'b0;
        mdl_out = model(o, w, x, y);
        mdl_lat = lat_of(w, x, y);
        mdl_start = cyc;
        mdl_active = 1'b1;
    endtask

    // mode 0: normal handshake; 1: en dropped together with out_ready; 2: stay in FINAL
    task automatic run_op(mul_op o, bit w, logic [63:0] x, logic [63:0] y, int hold, int mode,
                          output logic [63:0] got, output int lat);
        int t;
        start_op(o, w, x, y);
        t = 0;
        got = '0;
        lat = 0;
        while (!out_valid && t < 200) begin
            step();
            t++;
            if (t == 1) begin
                in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
                op = mul_op'($urandom_range(0, 3)); mul_word = $urandom_range(0, 1) == 1;
            end
        end
        if (!out_valid) begin
            chk("timeout_valid", 64'(out_valid), 64'h1);
            mdl_active = 1'b0;
            en = 1'b0;
            return;
        end
        got = out;
        lat = t;
        repeat (hold) step();
        if (mode == 2) return;
        out_ready = 1'b1;
        if (mode == 1) en = 1'b0;
        step();
        mdl_active = 1'b0;
        chk("idle_after_handshake", 64'(out_valid), 64'h0);
        en = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        int lat;
        repeat (3) step();
        chk("reset_valid", 64'(out_valid), 64'h0);
        chk("reset_out", out, 64'h0);
        reset = 1'b1;
        step();

        run_op(MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2, 0, got, lat);
        chk("mul_3_x_m5", got, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mul_latency", 64'(lat), 64'd65);
        run_op(MULH, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, got, lat);
        chk("mulh_min_min", got, 64'h4000_0000_0000_0000);
        run_op(MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, got, lat);
        chk("mulhsu_m1", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, got, lat);
        chk("mulhu_max", got, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MULHU, 1'b1, 64'h7FFF_FFFF, 64'd2, 0, 0, got, lat);
        chk("mulw", got, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulw_latency", 64'(lat), 64'd33);
        run_op(MUL, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 0, 1, got, lat);
        chk("mulw_garbage_hi", got, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MUL, 1'b0, 64'h1234, 64'h0, 10, 0, got, lat);
        chk("zero_skip_out", got, 64'h0);
        chk("zero_skip_latency", 64'(lat), 64'd1);

        for (int i = 0; i < 40; i++)
            run_op(mul_op'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, rnd_operand(),
                   rnd_operand(), $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 1 : 0, got, lat);

        // Abort: drop en once the iteration count has reached 20.
        start_op(MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        repeat (21) step();
        en = 1'b0;
        mdl_active = 1'b0;
        step();
        chk("abort_valid", 64'(out_valid), 64'h0);
        chk("abort_out", out, 64'h0);
        run_op(MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd17, 0, 0, got, lat);
        chk("after_abort", got, 64'hFFFF_FFFF_FFFF_FFFF);

        // Asynchronous reset mid-CAL, then a fresh 7*6.
        start_op(MUL, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);
        repeat (30) step();
        mdl_active = 1'b0;
        en = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_cal_valid", 64'(out_valid), 64'h0);
        chk("reset_cal_out", out, 64'h0);
        #1 reset = 1'b1;
        step();
        run_op(MUL, 1'b0, 64'd7, 64'd6, 0, 0, got, lat);
        chk("mul_7_x_6", got, 64'd42);

        // Asynchronous reset while a result waits in FINAL.
        run_op(MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 2, got, lat);
        chk("final_hold", got, 64'hFFFF_FFFF_FFFF_FFFE);
        mdl_active = 1'b0;
        en = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_final_valid", 64'(out_valid), 64'h0);
        chk("reset_final_out", out, 64'h0);
        #1 reset = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
